// File: rtl/enocoro_nibble_ctrl.sv
// Sequencing controller for the nibble-serial Enocoro-128v2 datapath: key/IV load,
// initialisation rounds, then keystream delivery one nibble at a time on valid/ready.
module enocoro_nibble_ctrl #(
  parameter int ROUND_CYCLES = 8,
  parameter int INIT_ROUNDS  = 96,
  parameter int LOAD_NIBBLES = 48
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       in_valid,
  input  logic [3:0] in_nib,
  output logic       in_ready,
  output logic       dp_load,
  output logic [3:0] dp_load_nib,
  output logic       dp_step,
  output logic       mux_c,
  input  logic [3:0] dp_ks_nib,
  output logic       ks_valid,
  output logic [3:0] ks_nib,
  input  logic       ks_ready,
  output logic [1:0] phase,
  output logic       busy
);

  localparam int NW = $clog2(LOAD_NIBBLES);
  localparam int CW = $clog2(ROUND_CYCLES);
  localparam int RW = $clog2(INIT_ROUNDS + 1);

  localparam logic [NW-1:0] NIB_LAST = NW'(LOAD_NIBBLES - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(ROUND_CYCLES - 1);
  localparam logic [CW-1:0] CYC_HI   = CW'(ROUND_CYCLES - 2);
  localparam logic [RW-1:0] RND_LAST = RW'(INIT_ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_INIT = 2'd2,
    ST_GEN  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [NW-1:0]   nib_cnt_q, nib_cnt_d;
  logic [CW-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [RW-1:0]   rnd_cnt_q, rnd_cnt_d;
  logic            stop_pend_q, stop_pend_d;
  logic            cyc_wrap;

  // Handshake: a nibble moves when valid and ready are both high in the same cycle.
  // in_ready depends only on state, ks_valid only on state and cyc_cnt, so neither
  // side's ready/valid can loop back into the other's.
  always_comb begin
    in_ready    = (state_q == ST_LOAD);
    dp_load     = in_ready & in_valid;
    dp_load_nib = dp_load ? in_nib : 4'd0;
    ks_valid    = (state_q == ST_GEN) && (cyc_cnt_q >= CYC_HI);
    ks_nib      = ks_valid ? dp_ks_nib : 4'd0;
    dp_step     = 1'b0;
    mux_c       = 1'b0;
    case (state_q)
      ST_LOAD: begin
        dp_step = in_valid;
        mux_c   = nib_cnt_q[0];
      end
      ST_INIT: begin
        dp_step = 1'b1;
        mux_c   = cyc_cnt_q[0];
      end
      ST_GEN: begin
        dp_step = ~ks_valid | ks_ready;
        mux_c   = cyc_cnt_q[0];
      end
      default: begin
        dp_step = 1'b0;
        mux_c   = 1'b0;
      end
    endcase
  end

  assign phase    = state_q;
  assign busy     = (state_q != ST_IDLE);
  assign cyc_wrap = (cyc_cnt_q == CYC_LAST);

  always_comb begin
    state_d     = state_q;
    nib_cnt_d   = nib_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    rnd_cnt_d   = rnd_cnt_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          nib_cnt_d   = '0;
          cyc_cnt_d   = '0;
          rnd_cnt_d   = '0;
          stop_pend_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          state_d   = ST_IDLE;
          nib_cnt_d = '0;
        end else if (dp_load) begin
          if (nib_cnt_q == NIB_LAST) begin
            state_d   = ST_INIT;
            nib_cnt_d = '0;
            cyc_cnt_d = '0;
            rnd_cnt_d = '0;
          end else begin
            nib_cnt_d = nib_cnt_q + 1'b1;
          end
        end
      end
      ST_INIT: begin
        if (stop) begin
          state_d   = ST_IDLE;
          cyc_cnt_d = '0;
          rnd_cnt_d = '0;
        end else if (cyc_wrap) begin
          cyc_cnt_d = '0;
          if (rnd_cnt_q == RND_LAST) begin
            state_d   = ST_GEN;
            rnd_cnt_d = '0;
          end else begin
            rnd_cnt_d = rnd_cnt_q + 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      ST_GEN: begin
        // A stop only takes effect on a round boundary so the byte in flight
        // always leaves as a complete high/low nibble pair.
        if (dp_step && cyc_wrap) begin
          cyc_cnt_d = '0;
          if (stop_pend_q | stop) begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
          end
        end else begin
          if (dp_step) begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
          end
          stop_pend_d = stop_pend_q | stop;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      nib_cnt_q   <= '0;
      cyc_cnt_q   <= '0;
      rnd_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nib_cnt_q   <= nib_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      rnd_cnt_q   <= rnd_cnt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

endmodule

// File: tb/tb_enocoro_nibble_ctrl.sv
// Bench for enocoro_nibble_ctrl: randomized stimulus checked every cycle against a
// phase/step-count model, plus literal timing expectations for the default sizes.
module tb_enocoro_nibble_ctrl;

  localparam int RC = 8;
  localparam int IR = 96;
  localparam int LN = 48;

  logic       clk = 1'b0;
  logic       reset_n, start, stop, in_valid, ks_ready;
  logic [3:0] in_nib, dp_ks_nib;
  logic       in_ready, dp_load, dp_step, mux_c, ks_valid, busy;
  logic [3:0] dp_load_nib, ks_nib;
  logic [1:0] phase;

  always #5 clk = ~clk;

  enocoro_nibble_ctrl #(.ROUND_CYCLES(RC), .INIT_ROUNDS(IR), .LOAD_NIBBLES(LN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .in_valid(in_valid), .in_nib(in_nib), .in_ready(in_ready),
    .dp_load(dp_load), .dp_load_nib(dp_load_nib), .dp_step(dp_step), .mux_c(mux_c),
    .dp_ks_nib(dp_ks_nib), .ks_valid(ks_valid), .ks_nib(ks_nib), .ks_ready(ks_ready),
    .phase(phase), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int tcyc = 0;

  // Model: phase plus plain event counts (nibbles loaded, INIT cycles, GEN steps).
  int m_phase, m_nibs, m_init, m_gen;
  bit m_pend;

  // Observed tallies and last sampled outputs for the literal checks.
  int n_load, n_init_step, n_hs, first_ks;
  logic o_ks_valid, o_mux, o_dp_step;
  logic [1:0] o_phase;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, tcyc, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, tcyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_phase = 0; m_nibs = 0; m_init = 0; m_gen = 0; m_pend = 0;
  endtask

  task automatic clear_tally();
    n_load = 0; n_init_step = 0; n_hs = 0; first_ks = -1;
  endtask

  task automatic model_advance(input logic st, input logic sp, input logic iv, input logic stp);
    case (m_phase)
      0: if (st) begin m_phase = 1; m_nibs = 0; m_pend = 0; end
      1: begin
        if (sp) m_phase = 0;
        else if (iv) begin
          m_nibs++;
          if (m_nibs == LN) begin m_phase = 2; m_init = 0; end
        end
      end
      2: begin
        if (sp) m_phase = 0;
        else begin
          m_init++;
          if (m_init == RC * IR) begin m_phase = 3; m_gen = 0; m_pend = 0; end
        end
      end
      default: begin
        if (stp) begin
          m_gen++;
          if ((m_gen % RC) == 0 && (m_pend || sp)) begin m_phase = 0; m_pend = 0; end
          else m_pend = m_pend | sp;
        end else begin
          m_pend = m_pend | sp;
        end
      end
    endcase
  endtask

  // One clock: drive at negedge, compare every output against the model, advance at posedge.
  task automatic step(input logic rn, input logic st, input logic sp, input logic iv, input logic kr);
    logic e_rdy, e_load, e_kv, e_step, e_mux;
    logic [3:0] e_lnib, e_knib;
    @(negedge clk);
    reset_n = rn; start = st; stop = sp; in_valid = iv; ks_ready = kr;
    in_nib = 4'($urandom_range(0, 15));
    dp_ks_nib = 4'($urandom_range(0, 15));
    if (!rn) model_clear();
    #1;
    e_rdy  = (m_phase == 1);
    e_load = e_rdy && iv;
    e_lnib = e_load ? in_nib : 4'd0;
    e_kv   = (m_phase == 3) && ((m_gen % RC) >= RC - 2);
    e_knib = e_kv ? dp_ks_nib : 4'd0;
    case (m_phase)
      1:       begin e_step = iv;             e_mux = (m_nibs % 2) == 1; end
      2:       begin e_step = 1'b1;           e_mux = (m_init % 2) == 1; end
      3:       begin e_step = !e_kv || kr;    e_mux = (m_gen % 2) == 1;  end
      default: begin e_step = 1'b0;           e_mux = 1'b0;              end
    endcase
    chk4("phase", {2'b00, phase}, 4'(m_phase));
    chk1("busy", busy, m_phase != 0);
    chk1("in_ready", in_ready, e_rdy);
    chk1("dp_load", dp_load, e_load);
    chk4("dp_load_nib", dp_load_nib, e_lnib);
    chk1("dp_step", dp_step, e_step);
    chk1("mux_c", mux_c, e_mux);
    chk1("ks_valid", ks_valid, e_kv);
    chk4("ks_nib", ks_nib, e_knib);
    o_phase = phase; o_ks_valid = ks_valid; o_mux = mux_c; o_dp_step = dp_step;
    if (dp_load === 1'b1) n_load++;
    if (phase == 2'd2 && dp_step === 1'b1) n_init_step++;
    if (ks_valid === 1'b1 && first_ks < 0) first_ks = tcyc;
    if (ks_valid === 1'b1 && ks_ready) n_hs++;
    @(posedge clk);
    if (rn) model_advance(st, sp, iv, e_step);
    tcyc++;
  endtask

  int t0, s, n;

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; ks_ready = 1'b0;
    in_nib = 4'd0; dp_ks_nib = 4'd0;
    model_clear();
    clear_tally();

    repeat (3) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    repeat (20) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    chk4("idle_after_reset", {2'b00, o_phase}, 4'd0);

    // Full default session with in_valid and ks_ready held high.
    clear_tally();
    t0 = tcyc;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    while (tcyc - t0 < 823 + 24) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_int("load_pulses", n_load, 48);
    chk_int("init_steps", n_init_step, 768);
    chk_int("first_ks_cycle", first_ks - t0, 823);
    chk_int("ks_nibbles_in_3_rounds", n_hs, 6);

    // Backpressure on a high-nibble cycle.
    n = 0;
    while (!(m_phase == 3 && (m_gen % RC) == RC - 2) && n < 20) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      n++;
    end
    s = tcyc;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk1("stall_dp_step", o_dp_step, 1'b0);
    chk1("stall_ks_valid", o_ks_valid, 1'b1);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_int("stall_low_nib_offset", tcyc - 1 - s, 6);
    chk1("stall_low_nib_valid", o_ks_valid, 1'b1);
    chk1("stall_low_nib_mux", o_mux, 1'b1);

    // Reset mid-GEN aborts immediately.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk4("reset_mid_gen_phase", {2'b00, o_phase}, 4'd0);
    chk1("reset_mid_gen_ks_valid", o_ks_valid, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Load with in_valid toggling, then ignored start and stop in INIT.
    clear_tally();
    t0 = tcyc;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 96; k++) step(1'b1, 1'b0, 1'b0, 1'((k % 2) == 1), 1'b1);
    chk_int("gap_load_pulses", n_load, 48);
    chk4("gap_init_entry", {2'b00, o_phase}, 4'd2);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    n = 0;
    while (m_init != 80 && n < 200) begin step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); n++; end
    chk_int("init_round10_reached", m_init, 80);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk4("stop_init_idle", {2'b00, o_phase}, 4'd0);
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Stop inside a GEN round: that round's two nibbles still go out.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    n = 0;
    while (!(m_phase == 3 && m_gen >= 2 * RC && (m_gen % RC) == 2) && n < 3000) begin
      step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      n++;
    end
    chk_int("gen_stop_point_reached", m_gen % RC, 2);
    clear_tally();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
    n = 0;
    while (o_phase != 2'd0 && n < 100) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      n++;
    end
    chk_int("gen_stop_nibbles", n_hs, 2);
    chk4("gen_stop_idle", {2'b00, o_phase}, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk4("restart_load", {2'b00, o_phase}, 4'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Start and stop together in IDLE: start wins.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk4("start_stop_idle", {2'b00, o_phase}, 4'd1);

    // Free-running random traffic.
    for (int k = 0; k < 4000; k++)
      step(1'b1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 999) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enocoro_nibble_ctrl.md
# enocoro_nibble_ctrl

Sequencing controller for the 4-bit nibble-serial Enocoro-128v2 datapath. Drives the nibble-phase select (mux_c) shared by the GF(2^8) multiply-by-0x02 slices, plus the datapath step/load strobes. Runs the full cipher lifecycle: key/IV nibble load, INIT_ROUNDS initialisation rounds, then keystream generation. Keystream leaves the controller one nibble at a time on a valid/ready handshake, with stall support.

## Interface
- ROUND_CYCLES, 8, clock cycles per cipher round; must be even and ≥ 4
- INIT_ROUNDS, 96, initialisation rounds before keystream
- LOAD_NIBBLES, 48, key+IV nibbles (128-bit key + 64-bit IV)

- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  begin session; honoured only in IDLE
- stop  in  1  end session request
- in_valid  in  1  key/IV nibble valid
- in_nib  in  4  key/IV nibble, key MS nibble first, then IV
- in_ready  out  1  controller accepts in_nib
- dp_load  out  1  datapath selects in_nib load path this cycle
- dp_load_nib  out  4  in_nib forwarded to datapath
- dp_step  out  1  datapath advances one nibble-cycle
- mux_c  out  1  nibble-phase select to multiplier slices
- dp_ks_nib  in  4  keystream nibble from datapath
- ks_valid  out  1  ks_nib valid
- ks_nib  out  4  keystream nibble (dp_ks_nib passed through)
- ks_ready  in  1  consumer accepts ks_nib
- phase  out  2  0 IDLE, 1 LOAD, 2 INIT, 3 GEN
- busy  out  1  phase != IDLE

## Operation
- Registers: state, nib_cnt ($clog2(LOAD_NIBBLES) bits), cyc_cnt ($clog2(ROUND_CYCLES)), rnd_cnt ($clog2(INIT_ROUNDS+1)), stop_pend.
- IDLE: all strobes 0, mux_c 0. start=1 → LOAD, clear all counters.
- LOAD: in_ready=1. Each in_valid&in_ready: dp_load=1, dp_step=1, nib_cnt++. Accepting nibble LOAD_NIBBLES-1 → INIT, cyc_cnt=rnd_cnt=0. in_valid=0 holds everything. mux_c = nib_cnt[0].
- INIT: dp_step=1 every cycle. cyc_cnt wraps ROUND_CYCLES-1→0, rnd_cnt++ on wrap. Wrap with rnd_cnt=INIT_ROUNDS-1 → GEN, counters 0.
- GEN: ks_valid=1 when cyc_cnt ∈ {ROUND_CYCLES-2, ROUND_CYCLES-1}, else 0. High nibble first, low nibble second.
- GEN stepping: dp_step = ~ks_valid | ks_ready. When dp_step=0, cyc_cnt and mux_c hold; ks_nib follows dp_ks_nib.
- mux_c = cyc_cnt[0] in INIT and GEN.
- stop: in LOAD or INIT → IDLE next cycle, no output. In GEN, sets stop_pend; exit to IDLE after the cyc_cnt wrap that completes the current round, so no round's byte is half-delivered. stop in IDLE is ignored.
- start outside IDLE is ignored.
- Simultaneous start+stop in IDLE: start wins.
- Simultaneous stop and round wrap in GEN: exit at that wrap.

## Timing
- Reset: state IDLE, all counters 0, stop_pend 0. All outputs 0 (in_ready, dp_load, dp_step, mux_c, ks_valid, busy, phase, dp_load_nib, ks_nib).
- Reset mid-session aborts immediately; next start begins a fresh LOAD.
- state is registered. in_ready, dp_load, dp_step, ks_valid and mux_c are combinational from state/counters/handshake inputs. No combinational path in_valid→in_ready or ks_ready→ks_valid.
- start sampled at edge N → phase=1 and in_ready=1 during cycle N+1.
- With in_valid held high, defaults: nibbles accepted cycles N+1..N+48; INIT cycles N+49..N+816; GEN from N+817.
- First ks_valid at N+823 (cyc_cnt=6), second nibble at N+824. Steady state: 2 nibbles per 8 cycles with ks_ready=1.
- Stall: ks_ready low for k cycles delays all subsequent activity by exactly k cycles.

## Test plan
- Reset/idle: reset_n low mid-GEN → all outputs 0 same cycle; after release, start=0 for 20 cycles → phase stays 0, dp_step 0.
- Full session, defaults, in_valid and ks_ready held 1, start at cycle 0 → exactly 48 dp_load pulses, then 768 dp_step cycles with mux_c toggling 0/1; first ks_valid at cycle 823; ks_valid pattern 0,0,0,0,0,0,1,1 repeating.
- Load gaps: in_valid toggled 1,0 every cycle → 48 accepts over 96 cycles; INIT starts the cycle after the 48th accept; nib_cnt never exceeds 47.
- Backpressure: ks_ready=0 for 5 cycles on a high-nibble cycle → ks_valid held, dp_step=0, mux_c constant; next nibble appears exactly 5 cycles later than unstalled.
- Stop handling: stop at INIT round 10 → IDLE next cycle, no ks_valid. stop pulsed at cyc_cnt=2 in GEN → both nibbles of that round still delivered, then IDLE; later start restarts LOAD.
- Ignored controls: start pulsed during INIT → no counter reset. stop in IDLE → no effect. Same-cycle start+stop in IDLE → enters LOAD.
